// File: rtl/conv_fifo_pkg.sv
// Shared definitions for the conv FIFO family: read-mode encodings and legal
// parameter ranges.
package conv_fifo_pkg;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  localparam int DATA_WIDTH_MIN  = 1;
  localparam int DATA_WIDTH_MAX  = 1152;
  localparam int DEPTH_WIDTH_MIN = 4;
  localparam int DEPTH_WIDTH_MAX = 16;

  function automatic bit fifo_params_legal(input int data_width, input int depth_width);
    return (data_width >= DATA_WIDTH_MIN) && (data_width <= DATA_WIDTH_MAX) &&
           (depth_width >= DEPTH_WIDTH_MIN) && (depth_width <= DEPTH_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/conv_sdpram.sv
// Simple dual-port RAM, one write port and one registered read port. The read
// register is clearable so the FIFO output can be forced to zero.
module conv_sdpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_sync_fifo.sv
// Single-clock FIFO with level/threshold flags, sticky error flags and optional
// first-word-fall-through read mode built on a registered-read RAM.
module conv_sync_fifo
  import conv_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 9,
  parameter int FWFT        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   flush,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  input  logic                   clr_err,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int              PW        = DEPTH_WIDTH + 1;
  localparam logic [PW-1:0]   DEPTH_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0]   ZERO_CNT  = '0;
  localparam bit              IS_FWFT   = (FWFT == int'(FWFT_ON));

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          out_valid_q, out_valid_d;

  logic          wr_acc;
  logic          rd_acc;
  logic          mem_has_word;
  logic          ram_re;
  logic          ram_clr;
  logic [PW-1:0] wr_inc;
  logic [PW-1:0] rd_dec;
  logic [PW-1:0] fetch_inc;

  always_comb begin
    wr_acc       = wr_en && !full_q && !flush;
    rd_acc       = rd_en && !empty_q && !flush;
    // Only words committed on an earlier edge are fetched, so the RAM never
    // sees a same-address read and write on one edge.
    mem_has_word = (wr_ptr_q != rd_ptr_q);
    if (IS_FWFT) begin
      ram_re = mem_has_word && (!out_valid_q || rd_acc) && !flush;
    end else begin
      ram_re = rd_acc;
    end
    ram_clr   = flush && IS_FWFT;
    wr_inc    = {{DEPTH_WIDTH{1'b0}}, wr_acc};
    rd_dec    = {{DEPTH_WIDTH{1'b0}}, rd_acc};
    fetch_inc = {{DEPTH_WIDTH{1'b0}}, ram_re};
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + wr_inc;
    rd_ptr_d    = rd_ptr_q + fetch_inc;
    level_d     = level_q + wr_inc - rd_dec;
    out_valid_d = IS_FWFT ? (ram_re || (out_valid_q && !rd_acc)) : 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end

    full_d  = (level_d == DEPTH_CNT);
    // In FWFT mode "not empty" means the output stage holds a word.
    empty_d = IS_FWFT ? !out_valid_d : (level_d == ZERO_CNT);
    af_d    = flush ? 1'b0 : (level_d >= af_thresh);
    ae_d    = flush ? 1'b1 : (level_d <= ae_thresh);

    // Setting wins over a coincident clear.
    if (wr_en && full_q && !flush) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rd_en && empty_q && !flush) begin
      unf_d = 1'b1;
    end else if (clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  conv_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ram_clr),
    .we    (wr_acc),
    .waddr (wr_ptr_q[DEPTH_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_q[DEPTH_WIDTH-1:0]),
    .rdata (rd_data)
  );

  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: doc/conv_sync_fifo.md
CONV_SYNC_FIFO -- requirements
Module: conv_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data width in bits, legal 1..1152.
REQ-002 Parameter DEPTH_WIDTH, default 9: capacity DEPTH = 2^DEPTH_WIDTH words, legal 4..16.
REQ-003 Parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 wr_en  in  1  write request.
REQ-007 wr_data  in  DATA_WIDTH  write data.
REQ-008 rd_en  in  1  read request (pop in FWFT).
REQ-009 rd_data  out  DATA_WIDTH  read data.
REQ-010 flush  in  1  synchronous clear of contents.
REQ-011 af_thresh  in  DEPTH_WIDTH+1  almost-full threshold.
REQ-012 ae_thresh  in  DEPTH_WIDTH+1  almost-empty threshold.
REQ-013 clr_err  in  1  clears the sticky error flags.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  registered status flags.
REQ-015 level  out  DEPTH_WIDTH+1  words held, 0..DEPTH.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Write is accepted when wr_en=1 and registered full=0; read is accepted when rd_en=1 and registered empty=0.
REQ-018 Write and read pointers are DEPTH_WIDTH+1 bits and wrap modulo 2*DEPTH; the memory address is the low DEPTH_WIDTH bits.
REQ-019 level increments on write-only, decrements on read-only, and is unchanged on simultaneous accepted read and write; capacity is exactly DEPTH in both modes, counting the FWFT output stage.
REQ-020 full=(level==DEPTH), empty=(level==0); all flags and level update on the clock edge that accepts the transfer.
REQ-021 almost_full=(level>=af_thresh), almost_empty=(level<=ae_thresh), using the next level value; threshold changes take effect on the next edge.
REQ-022 Standard mode: rd_data presents the popped word one cycle after the accepted read and holds between reads.
REQ-023 FWFT mode: rd_data shows the head word whenever empty=0; an accepted read advances it in the same cycle; on a write into an empty FIFO, empty deasserts 1 cycle after the write edge.
REQ-024 At full with wr_en and rd_en both high: the read is accepted, the write is rejected, and overflow sets.
REQ-025 At empty with wr_en and rd_en both high: the write is accepted, the read is rejected, and underflow sets.
REQ-026 A rejected write sets overflow; a rejected read sets underflow; both hold until clr_err=1 or reset. If a set condition and clr_err coincide, the flag is set.
REQ-027 flush=1 has reset effect on pointers, level, flags and the FWFT output stage (not on overflow/underflow or memory), and takes priority over a same-cycle wr_en/rd_en.

Reset
REQ-028 With rst_n=0 at a clock edge: pointers=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-029 Memory contents are not reset; reset mid-transfer discards all held words and any in-flight read.

Structure
REQ-030 Mode encodings (FWFT_OFF/FWFT_ON) and legal parameter range constants are defined in the shared package conv_fifo_pkg.
REQ-031 Storage is the sub-module conv_sdpram: a simple dual-port RAM with registered read, DATA_WIDTH x DEPTH. Control logic stays in conv_sync_fifo.

Verification
REQ-032 FWFT=0, DEPTH_WIDTH=4: write 0x01..0x10 -> full=1 and level=16 after the 16th edge; a 17th write -> overflow=1 and level stays 16.
REQ-033 FWFT=0: from 16 words, read 16 -> rd_data=0x01..0x10 in order, each one cycle after its read; a 17th read -> underflow=1.
REQ-034 FWFT=1: single write of 0xA5 into an empty FIFO -> empty=0 and rd_data=0xA5 one cycle later without rd_en; rd_en pop -> empty=1 next edge.
REQ-035 Full FIFO with wr_en=rd_en=1 for one cycle -> level=15, overflow=1; empty FIFO with both high -> level=1, underflow=1.
REQ-036 af_thresh=12, ae_thresh=3: fill 0->16 -> almost_empty falls at level 4 and almost_full rises at level 12; then push 40 words through with wraparound -> data order preserved.
REQ-037 flush asserted at level 9 alongside wr_en -> level=0, empty=1, overflow unchanged; rst_n=0 mid-burst -> all REQ-028 values next edge.
